// File: rtl/js_phase_monitor_pkg.sv
// Shared definitions for the Johnson-counter phase monitor: code constants,
// monitor state encoding and the code-to-index decode.
package js_phase_monitor_pkg;

    // 8-state Johnson codes, written with Q[0] as the MSB
    localparam logic [3:0] JS_S0 = 4'b0000;
    localparam logic [3:0] JS_S1 = 4'b1000;
    localparam logic [3:0] JS_S2 = 4'b1100;
    localparam logic [3:0] JS_S3 = 4'b1110;
    localparam logic [3:0] JS_S4 = 4'b1111;
    localparam logic [3:0] JS_S5 = 4'b0111;
    localparam logic [3:0] JS_S6 = 4'b0011;
    localparam logic [3:0] JS_S7 = 4'b0001;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } mon_state_t;

    // Returns {legal, index[2:0]}; illegal codes return index 0 with legal low
    function automatic logic [3:0] js_decode_code(input logic [3:0] code);
        logic [3:0] res;
        case (code)
            JS_S0:   res = 4'b1_000;
            JS_S1:   res = 4'b1_001;
            JS_S2:   res = 4'b1_010;
            JS_S3:   res = 4'b1_011;
            JS_S4:   res = 4'b1_100;
            JS_S5:   res = 4'b1_101;
            JS_S6:   res = 4'b1_110;
            JS_S7:   res = 4'b1_111;
            default: res = 4'b0_000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/js_phase_monitor_decode.sv
// Combinational Johnson code decoder: Q -> {legal, index}.
module js_decode
    import js_phase_monitor_pkg::*;
(
    input  logic [0:3] q,
    output logic       legal,
    output logic [2:0] index
);

    logic [3:0] code;

    // q[0] lands in the MSB of code, matching the package constants
    always_comb begin
        code           = q;
        {legal, index} = js_decode_code(code);
    end

endmodule

// File: rtl/js_phase_monitor.sv
// Johnson-counter phase monitor.
//   state    | meaning
//   ST_SYNC  | waiting for S0 to lock onto the sequence
//   ST_TRACK | following a legal sequence, stalls tolerated
//   ST_FAULT | illegal/skip/reverse seen; outputs frozen until ACK
module js_phase_monitor
    import js_phase_monitor_pkg::*;
#(
    parameter int CYC_W = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [0:3]       Q,
    input  logic             ACK,
    output logic [7:0]       PHASE,
    output logic [2:0]       STEP,
    output logic             VALID,
    output logic             WRAP,
    output logic             ERR,
    output logic [CYC_W-1:0] CYC_CNT
);

    mon_state_t       state_q, state_d;
    logic [7:0]       phase_q, phase_d;
    logic [2:0]       step_q, step_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [CYC_W-1:0] cnt_q, cnt_d;

    logic             code_legal;
    logic [2:0]       code_idx;
    logic [2:0]       step_nxt;

    js_decode u_decode (
        .q     (Q),
        .legal (code_legal),
        .index (code_idx)
    );

    // Next-state and next-output computation; WRAP defaults low every cycle
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        step_d   = step_q;
        valid_d  = valid_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        step_nxt = step_q + 3'd1;
        case (state_q)
            ST_SYNC: begin
                if (code_legal && code_idx == 3'd0) begin
                    state_d = ST_TRACK;
                    phase_d = 8'h01;
                    step_d  = 3'd0;
                    valid_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (code_legal && code_idx == step_q) begin
                    state_d = ST_TRACK;
                end else if (code_legal && code_idx == step_nxt) begin
                    phase_d = 8'h01 << code_idx;
                    step_d  = code_idx;
                    if (code_idx == 3'd0) begin
                        wrap_d = 1'b1;
                        if (cnt_q != {CYC_W{1'b1}}) begin
                            cnt_d = cnt_q + CYC_W'(1);
                        end
                    end
                end else begin
                    state_d = ST_FAULT;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                    phase_d = 8'h00;
                end
            end
            ST_FAULT: begin
                if (ACK) begin
                    state_d = ST_SYNC;
                    err_d   = 1'b0;
                    phase_d = 8'h00;
                    step_d  = 3'd0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_SYNC;
                phase_d = 8'h00;
                step_d  = 3'd0;
                valid_d = 1'b0;
                err_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low clear
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= ST_SYNC;
            phase_q <= 8'h00;
            step_q  <= 3'd0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            step_q  <= step_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PHASE   = phase_q;
    assign STEP    = step_q;
    assign VALID   = valid_q;
    assign WRAP    = wrap_q;
    assign ERR     = err_q;
    assign CYC_CNT = cnt_q;

endmodule

// File: tb/tb_js_phase_monitor.sv
// Scoreboard bench for js_phase_monitor: two instances (CYC_W=8 and CYC_W=2)
// share the same stimulus; a reference model predicts every cycle's outputs.
module tb_js_phase_monitor;

    logic       CLK = 1'b0;
    logic       CLR;
    logic [0:3] Q;
    logic       ACK;

    logic [7:0] ph8, ph2;
    logic [2:0] st8, st2;
    logic       v8, v2, w8, w2, e8, e2;
    logic [7:0] cnt8;
    logic [1:0] cnt2;

    js_phase_monitor #(.CYC_W(8)) dut8 (
        .CLK(CLK), .CLR(CLR), .Q(Q), .ACK(ACK),
        .PHASE(ph8), .STEP(st8), .VALID(v8), .WRAP(w8), .ERR(e8), .CYC_CNT(cnt8)
    );

    js_phase_monitor #(.CYC_W(2)) dut2 (
        .CLK(CLK), .CLR(CLR), .Q(Q), .ACK(ACK),
        .PHASE(ph2), .STEP(st2), .VALID(v2), .WRAP(w2), .ERR(e2), .CYC_CNT(cnt2)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] phase;
        logic [2:0] step;
        logic       valid;
        logic       wrap;
        logic       err;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Reference model: Johnson sequence as a table, position as an integer
    logic [3:0] codes [8] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110,
                              4'b1111, 4'b0111, 4'b0011, 4'b0001};
    bit m_track = 0;
    bit m_fault = 0;
    int m_step  = 0;
    int m_revs  = 0;

    function automatic int lookup(input logic [3:0] c);
        for (int i = 0; i < 8; i++) if (codes[i] == c) return i;
        return -1;
    endfunction

    task automatic cyc(input bit clr, input logic [3:0] code, input bit ack);
        exp_t e;
        int   idx;
        bit   wrap;
        @(negedge CLK);
        CLR  = clr;
        Q    = code;
        ACK  = ack;
        wrap = 0;
        idx  = lookup(code);
        if (!clr) begin
            m_track = 0; m_fault = 0; m_step = 0; m_revs = 0;
        end else if (m_fault) begin
            if (ack) begin m_fault = 0; m_step = 0; end
        end else if (!m_track) begin
            if (idx == 0) begin m_track = 1; m_step = 0; end
        end else if (idx == m_step) begin
            // stall
        end else if (idx >= 0 && idx == (m_step + 1) % 8) begin
            m_step = idx;
            if (idx == 0) begin wrap = 1; m_revs++; end
        end else begin
            m_track = 0; m_fault = 1;
        end
        e.phase = m_track ? (8'h01 << m_step) : 8'h00;
        e.step  = 3'(m_step);
        e.valid = m_track;
        e.wrap  = wrap;
        e.err   = m_fault;
        e.c8    = 8'((m_revs > 255) ? 255 : m_revs);
        e.c2    = 2'((m_revs > 3) ? 3 : m_revs);
        exp_q.push_back(e);
    endtask

    task automatic go_to(input int n);
        for (int i = 0; i <= n; i++) cyc(1, codes[i], 0);
    endtask

    // Monitor: outputs are presented every cycle, compared just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                if (ph8 !== e.phase || st8 !== e.step || v8 !== e.valid ||
                    w8 !== e.wrap || e8 !== e.err || cnt8 !== e.c8 ||
                    ph2 !== e.phase || st2 !== e.step || v2 !== e.valid ||
                    w2 !== e.wrap || e2 !== e.err || cnt2 !== e.c2) begin
                    miscompares++;
                    $display("FAIL vec%0d outputs: got w8 ph=%h st=%0d v=%b w=%b e=%b cnt=%0d | w2 ph=%h st=%0d v=%b w=%b e=%b cnt=%0d ; want ph=%h st=%0d v=%b w=%b e=%b cnt8=%0d cnt2=%0d",
                             vectors, ph8, st8, v8, w8, e8, cnt8, ph2, st2, v2, w2, e2, cnt2,
                             e.phase, e.step, e.valid, e.wrap, e.err, e.c8, e.c2);
                end
            end
        end
    end

    initial begin
        int r;
        int budget;
        CLR = 1'b0; Q = 4'b0000; ACK = 1'b0;
        cyc(0, codes[0], 0);
        cyc(0, codes[0], 0);

        // full revolution with wrap
        for (int i = 0; i < 8; i++) cyc(1, codes[i], 0);
        cyc(1, codes[0], 0);
        // stalls at S2
        cyc(1, codes[1], 0);
        cyc(1, codes[2], 0); cyc(1, codes[2], 0); cyc(1, codes[2], 0);
        cyc(1, codes[3], 0);
        // illegal code at S3, frozen fault, ACK, resync
        cyc(1, 4'b1010, 0);
        cyc(1, codes[4], 0); cyc(1, codes[0], 0);
        cyc(1, codes[0], 1);
        cyc(1, codes[5], 0);
        cyc(1, codes[0], 0);
        // ACK ignored in TRACK; fault wins over ACK
        cyc(1, codes[1], 1);
        cyc(1, 4'b0101, 1);
        cyc(1, codes[2], 1);
        // ACK in SYNC ignored; skip and reverse from S4
        cyc(1, codes[3], 1);
        go_to(4); cyc(1, codes[6], 0); cyc(1, codes[6], 0);
        cyc(0, codes[0], 0);
        go_to(4); cyc(1, codes[3], 0); cyc(1, codes[3], 0);
        // five revolutions: narrow counter saturates at 3
        cyc(0, codes[0], 0);
        cyc(1, codes[0], 0);
        for (int k = 0; k < 5; k++)
            for (int i = 1; i <= 8; i++) cyc(1, codes[i % 8], 0);
        // reset at S5 with ACK high, then S5 must not resync
        go_to(5);
        cyc(0, codes[5], 1);
        cyc(1, codes[5], 0); cyc(1, codes[5], 0);
        // reset while in FAULT
        go_to(2); cyc(1, codes[7], 0);
        cyc(0, codes[0], 1);
        // long legal run with random stalls to saturate the wide counter
        cyc(1, codes[0], 0);
        for (int k = 0; k < 262; k++)
            for (int i = 1; i <= 8; i++) begin
                if ($urandom_range(0, 9) == 0) cyc(1, codes[i - 1], 0);
                cyc(1, codes[i % 8], 0);
            end
        // randomized mix
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] c;
            r = $urandom_range(0, 99);
            if (m_track && r < 85)
                c = ($urandom_range(0, 3) == 0) ? codes[m_step] : codes[(m_step + 1) % 8];
            else if (r < 30)
                c = codes[0];
            else
                c = 4'($urandom_range(0, 15));
            cyc(($urandom_range(0, 49) != 0), c, ($urandom_range(0, 3) == 0));
        end

        budget = 0;
        while (exp_q.size() > 0 && budget < 20) begin
            @(posedge CLK);
            budget++;
        end
        #2;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
